// File: rtl/window_buffer_ctrl_param.sv
// Frame controller for a WIN x WIN sliding-window buffer on a raster pixel stream.
// Optional downstream backpressure is enabled by defining WBC_BACKPRESSURE_EN.
module window_buffer_ctrl_param #(
  parameter int unsigned WIN   = 9,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     pix_valid_i,
`ifdef WBC_BACKPRESSURE_EN
  input  logic                     ready_i,
`endif
  output logic                     pix_ready_o,
  output logic                     shift_en_o,
  output logic                     win_valid_o,
  output logic [$clog2(IMG_H)-1:0] row_o,
  output logic [$clog2(IMG_W)-1:0] col_o,
  output logic                     busy_o,
  output logic                     frame_done_o
);

  localparam int unsigned CW   = $clog2(IMG_W);
  localparam int unsigned RW   = $clog2(IMG_H);
  localparam int unsigned HALF = (WIN - 1) / 2;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_EDGE  = CW'(WIN - 1);
  localparam logic [CW-1:0] COL_HALF  = CW'(HALF);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_EDGE  = RW'(WIN - 1);
  localparam logic [RW-1:0] ROW_FILLN = RW'(WIN - 2);
  localparam logic [RW-1:0] ROW_HALF  = RW'(HALF);

  typedef enum logic [1:0] {IDLE, FILL, ACTIVE, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          accept;
  logic          would_emit;
  logic          col_last;
  logic          last_pix;

  assign would_emit = (row_cnt >= ROW_EDGE) && (col_cnt >= COL_EDGE);
  assign col_last   = (col_cnt == COL_LAST);
  assign last_pix   = col_last && (row_cnt == ROW_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = FILL;
      FILL:    if (accept && col_last && (row_cnt == ROW_FILLN)) state_nxt = ACTIVE;
      ACTIVE:  if (accept && last_pix) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs; a stalled emitting pixel is held off when backpressured
  always_comb begin
    busy_o       = 1'b0;
    frame_done_o = 1'b0;
    pix_ready_o  = 1'b0;
    case (state)
      FILL, ACTIVE: busy_o = 1'b1;
      DONE:         frame_done_o = 1'b1;
      default:      ;
    endcase
`ifdef WBC_BACKPRESSURE_EN
    pix_ready_o = busy_o && (ready_i || !would_emit);
`else
    pix_ready_o = busy_o;
`endif
    accept     = pix_valid_i && pix_ready_o;
    shift_en_o = accept;
  end

  // Raster counters: advance per accepted pixel, clear after the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      if (last_pix) begin
        col_cnt <= '0;
        row_cnt <= '0;
      end else if (col_last) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + RW'(1);
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end
    end
  end

  // Window-complete flag and centre coordinates for the pixel just accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid_o <= 1'b0;
      row_o       <= '0;
      col_o       <= '0;
    end else begin
      win_valid_o <= accept && would_emit;
      if (accept && would_emit) begin
        row_o <= row_cnt - ROW_HALF;
        col_o <= col_cnt - COL_HALF;
      end
    end
  end

endmodule
